// File: rtl/debug_frame_responder_if.sv
// Frame link bundle: MicroBlaze command/return frames plus the pipeline run-control
// and debug-source select/data lines seen by the responder.
interface debug_frame_responder_if #(
   parameter int NB_CONTROL_FRAME = 32,
   parameter int NB_SRC           = 96
);
   logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze;
   logic                        i_halt;
   logic [NB_SRC-1:0]           i_src_data;
   logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze;
   logic                        o_run_enable;
   logic                        o_soft_reset;
   logic [8:0]                  o_src_type;
   logic [15:0]                 o_src_addr;

   modport master (
      output i_frame_from_blaze, i_halt, i_src_data,
      input  o_frame_to_blaze, o_run_enable, o_soft_reset, o_src_type, o_src_addr
   );
   modport slave (
      input  i_frame_from_blaze, i_halt, i_src_data,
      output o_frame_to_blaze, o_run_enable, o_soft_reset, o_src_type, o_src_addr
   );
endinterface

// File: rtl/debug_frame_responder.sv
// MIPS-side control-frame responder: run control from MicroBlaze commands and a
// snapshot-based multi-word debug readout on the return frame.
module debug_frame_responder #(
   parameter int NB_CONTROL_FRAME = 32,
   parameter int NB_SRC           = 96
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   debug_frame_responder_if.slave  bus
);
   localparam logic [5:0] C_START     = 6'b000001;
   localparam logic [5:0] C_RESET     = 6'b000010;
   localparam logic [5:0] C_REQ_DATA  = 6'b000011;
   localparam logic [5:0] C_MODE_GET  = 6'b001000;
   localparam logic [5:0] C_MODE_CONT = 6'b001001;
   localparam logic [5:0] C_MODE_STEP = 6'b001010;
   localparam logic [5:0] C_STEP      = 6'b100000;
   localparam logic [5:0] C_GOT_DATA  = 6'b100100;
   localparam logic [5:0] C_GIB_DATA  = 6'b100101;

   localparam int SHADOW_W = 4 * NB_CONTROL_FRAME;

   typedef struct packed {
      logic [5:0]  code;
      logic        valid;
      logic [8:0]  addr_type;
      logic [15:0] address;
   } cmd_frame_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_SEND} state_t;
   typedef logic [3:0][NB_CONTROL_FRAME-1:0] shadow_t;

   function automatic logic [1:0] type_words(input logic [8:0] t);
      case (t)
         9'b000000001, 9'b000000010, 9'b000000100,
         9'b000000101, 9'b000001000:               type_words = 2'd1;
         9'b000001001, 9'b000010001, 9'b000100000,
         9'b000100001, 9'b001000000, 9'b001000001: type_words = 2'd2;
         9'b000010000:                             type_words = 2'd3;
         default:                                  type_words = 2'd0;
      endcase
   endfunction

   function automatic logic [NB_CONTROL_FRAME-1:0] status_word(
      input logic err, input logic done, input logic mode_step, input logic running);
      status_word = {8'hA5, 19'b0, err, done, mode_step, running, 1'b0};
   endfunction

   cmd_frame_t cmd;
   logic [SHADOW_W-1:0] src_ext;
   logic accept;
   logic [1:0] req_words, cur_words;

   state_t  state_q, state_n;
   logic    running_q, running_n;
   logic    mode_step_q, mode_step_n;
   logic    err_q, err_n, done_q, done_n;
   logic    prev_valid_q;
   logic    step_pulse_q, step_pulse_n;
   logic    soft_reset_q, soft_reset_n;
   logic [1:0] idx_q, idx_n;
   shadow_t shadow_q, shadow_n;
   logic [8:0]  src_type_q, src_type_n;
   logic [15:0] src_addr_q, src_addr_n;
   logic [NB_CONTROL_FRAME-1:0] frame_q, frame_n;

   assign cmd       = cmd_frame_t'(bus.i_frame_from_blaze[31:0]);
   assign src_ext   = SHADOW_W'(bus.i_src_data);
   assign accept    = cmd.valid & ~prev_valid_q;
   assign req_words = type_words(cmd.addr_type);
   assign cur_words = type_words(src_type_q);

   always_comb begin
      state_n      = state_q;
      running_n    = running_q;
      mode_step_n  = mode_step_q;
      err_n        = err_q;
      done_n       = done_q;
      idx_n        = idx_q;
      shadow_n     = shadow_q;
      src_type_n   = src_type_q;
      src_addr_n   = src_addr_q;
      step_pulse_n = 1'b0;
      soft_reset_n = 1'b0;

      // SEL exists only so the mux output settles for one cycle before the snapshot
      if (state_q == ST_SEL) begin
         shadow_n = src_ext;
         idx_n    = 2'd0;
         state_n  = ST_SEND;
      end

      if (accept) begin
         case (cmd.code)
            C_START:     running_n = 1'b1;
            C_RESET: begin
               soft_reset_n = 1'b1;
               running_n    = 1'b0;
               mode_step_n  = 1'b0;
               state_n      = ST_IDLE;
               err_n        = 1'b0;
               done_n       = 1'b0;
            end
            C_MODE_CONT: mode_step_n = 1'b0;
            C_MODE_STEP: mode_step_n = 1'b1;
            C_STEP:      step_pulse_n = running_q & mode_step_q;
            C_MODE_GET:  ;
            C_REQ_DATA: begin
               if (state_q != ST_IDLE) begin
                  err_n = 1'b1;
               end else if (req_words == 2'd0) begin
                  err_n  = 1'b1;
                  done_n = 1'b0;
               end else begin
                  src_type_n = cmd.addr_type;
                  src_addr_n = cmd.address;
                  err_n      = 1'b0;
                  done_n     = 1'b0;
                  state_n    = ST_SEL;
               end
            end
            C_GOT_DATA: begin
               if (state_q == ST_IDLE) begin
                  err_n = 1'b1;
               end else if (state_q == ST_SEND) begin
                  if (idx_q == cur_words - 2'd1) begin
                     done_n  = 1'b1;
                     state_n = ST_IDLE;
                  end else begin
                     idx_n = idx_q + 2'd1;
                  end
               end
            end
            C_GIB_DATA: begin
               if (state_q == ST_IDLE) begin
                  err_n = 1'b1;
               end else if (state_q == ST_SEND) begin
                  if (cmd.address < {14'b0, cur_words}) idx_n = cmd.address[1:0];
                  else                                   err_n = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (bus.i_halt) running_n = 1'b0;

      frame_n = (state_n == ST_SEND) ? shadow_n[idx_n]
                                     : status_word(err_n, done_n, mode_step_n, running_n);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         running_q    <= 1'b0;
         mode_step_q  <= 1'b0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         prev_valid_q <= 1'b1;
         step_pulse_q <= 1'b0;
         soft_reset_q <= 1'b0;
         idx_q        <= 2'd0;
         shadow_q     <= '0;
         src_type_q   <= '0;
         src_addr_q   <= '0;
         frame_q      <= 32'hA500_0000;
      end else begin
         state_q      <= state_n;
         running_q    <= running_n;
         mode_step_q  <= mode_step_n;
         err_q        <= err_n;
         done_q       <= done_n;
         prev_valid_q <= cmd.valid;
         step_pulse_q <= step_pulse_n;
         soft_reset_q <= soft_reset_n;
         idx_q        <= idx_n;
         shadow_q     <= shadow_n;
         src_type_q   <= src_type_n;
         src_addr_q   <= src_addr_n;
         frame_q      <= frame_n;
      end
   end

   assign bus.o_frame_to_blaze = frame_q;
   assign bus.o_run_enable     = (running_q & ~mode_step_q) | step_pulse_q;
   assign bus.o_soft_reset     = soft_reset_q;
   assign bus.o_src_type       = src_type_q;
   assign bus.o_src_addr       = src_addr_q;
endmodule

// File: doc/debug_frame_responder.md
# debug_frame_responder

MIPS-side end of the MicroBlaze control-frame link: decodes 32-bit command frames from the MicroBlaze and drives pipeline run control (start, soft reset, continuous/step mode, single step). It also serves debug readout: snapshots a selected latch, register or memory word and returns it as a sequence of 32-bit words on the return frame. It sits between the GPIO frame ports and the pipeline's debug-source mux.

## Interface
- NB_CONTROL_FRAME, 32, frame width in both directions
- NB_SRC, 96, width of debug-source data bus (widest source 85 bits, 3 words)
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_frame_from_blaze  in  32  {code[31:26], valid[25], addr_type[24:16], address[15:0]}
- i_halt  in  1  pipeline executed HALT (1-cycle pulse)
- i_src_data  in  NB_SRC  data of the source selected by o_src_type/o_src_addr, zero-extended; valid 1 cycle after the selects change
- o_frame_to_blaze  out  32  status word or data word (registered)
- o_run_enable  out  1  pipeline clock-enable
- o_soft_reset  out  1  1-cycle pipeline reset pulse
- o_src_type  out  9  registered source select (addr_type of REQ_DATA)
- o_src_addr  out  16  registered address (register or memory index)

## Operation
- Accept a command only on the rising edge of valid: valid=1 and prev_valid=0. prev_valid resets to 1, so a frame held through reset is not executed.
- Codes:
  - START 000001: running=1.
  - RESET 000010: o_soft_reset=1 for 1 cycle, running=0, mode=cont, abort any transfer, clear err/done.
  - MODE_SET_CONT 001001 / MODE_SET_STEP 001010: set mode.
  - STEP 100000: one o_run_enable pulse if running and mode=step; otherwise ignored.
  - MODE_GET 001000: no state change; status word is refreshed.
  - REQ_DATA 000011, GOT_DATA 100100, GIB_DATA 100101: readout, below.
  - Any other code (including LOAD_INSTR_*): no effect.
- o_run_enable = running & mode_cont, or the 1-cycle step pulse. i_halt clears running. i_halt takes priority over a same-cycle START.
- Word count by addr_type:
  - 1 word: MEM_DATA 000000001, MEM_INSTR 000000010, REG 000000100, REG_PC 000000101, FETCH_DATA 000001000.
  - 2 words: FETCH_CTRL 000001001, DECO_CTRL 000010001, EXEC_DATA 000100000, EXEC_CTRL 000100001, MEM_DATA_L 001000000, MEM_CTRL 001000001.
  - 3 words: DECO_DATA 000010000.
  - Any other type: err=1, no transfer.
- FSM IDLE/SEL/SEND:
  - IDLE + REQ_DATA with a valid type: latch o_src_type/o_src_addr, clear done, go to SEL.
  - SEL (1 cycle): shadow <= i_src_data, idx=0, go to SEND.
  - SEND: o_frame_to_blaze = shadow[32*idx +: 32].
    - GOT_DATA: if idx = nwords-1, set done and go to IDLE; else idx+1.
    - GIB_DATA: if address < nwords, idx = address[1:0]; else err=1 and idx is unchanged.
  - REQ_DATA outside IDLE: err=1, transfer continues.
  - GOT_DATA/GIB_DATA in IDLE: err=1.
- Status word (IDLE/SEL): {8'hA5, 19'b0, err, done, mode_step, running, 1'b0}. err and done clear on the next accepted REQ_DATA or RESET.
- The shadow decouples readout from the pipeline: the pipeline keeps running during a transfer.

## Timing
- Reset values:
  - o_frame_to_blaze = 32'hA500_0000
  - o_run_enable = 0, o_soft_reset = 0
  - o_src_type = 0, o_src_addr = 0
  - running = 0, mode = cont, state = IDLE, err = 0, done = 0, prev_valid = 1
- Command sampled at edge E0 → all effects registered at E0 and visible in the cycle after.
- REQ_DATA at E0: selects valid after E0; shadow captured at E1; word 0 on the frame after E1 (2-cycle latency).
- GOT_DATA/GIB_DATA at E: new word visible after E.
- i_reset mid-transfer: immediate return to reset values; the shadow content is don't-care.
- A valid level held for many cycles executes once.

## Test plan
- Reset, then MODE_SET_CONT, then START (each valid for 1 cycle) → o_run_enable=1 from the cycle after START; status = 32'hA500_0002.
- MODE_SET_STEP, START, STEP ×3 → exactly three 1-cycle o_run_enable pulses; STEP before START gives no pulse; i_halt → running=0 (status bit1 clear).
- REQ_DATA type 000010000, i_src_data = 96'h0000_0000_0015_AAAA_BBBB_CCCC_DDDD_EEEE (85-bit value, upper bits zero) → 2 cycles later frame = DDDD_EEEE; GOT → BBBB_CCCC; GOT → 0015_AAAA; GOT → status 32'hA500_0008 (done).
- In SEND, GIB_DATA address 0 → word 0 re-presented; GIB_DATA address 3 on a 3-word type → err set, word unchanged; after completion status bit4 = 1.
- REQ_DATA with type 000000011 → no transfer, err=1; GOT_DATA in IDLE → err=1; RESET → o_soft_reset pulse, status back to 32'hA500_0000.
- Valid held high for 5 cycles with START, and i_reset asserted during SEND → START executed once; after reset, outputs at reset values and a fresh REQ_DATA succeeds.
